// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the writeback request bus, the register-file write port and the
//   pending-write scoreboard port of regfile_wb_arbiter.
//
//   master modport : requesters + issue stage (drive valid/addr/data, sb_set)
//   slave  modport : the arbiter (drives req_ready, rf_*, sb_busy)
//
//   Signals
//     hold       1         freeze: no grants this cycle
//     req_valid  NREQ      requester i has a write pending
//     req_addr   NREQ*AW   destination register of requester i (slice i)
//     req_data   NREQ*DW   write data of requester i (slice i)
//     req_ready  NREQ      one-hot grant
//     rf_we      1         register file we3
//     rf_a3      AW        register file a3
//     rf_wd3     DW        register file wd3
//     sb_set     1         issue stage allocates destination sb_addr
//     sb_addr    AW        register being allocated
//     sb_busy    32        bit r = 1: write to xr outstanding
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_a3;
    logic [DW-1:0]        rf_wd3;
    logic                 sb_set;
    logic [AW-1:0]        sb_addr;
    logic [31:0]          sb_busy;

    modport master (
        output hold, req_valid, req_addr, req_data, sb_set, sb_addr,
        input  req_ready, rf_we, rf_a3, rf_wd3, sb_busy
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data, sb_set, sb_addr,
        output req_ready, rf_we, rf_a3, rf_wd3, sb_busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between NREQ writeback
//   requesters (0=ALU, 1=LSU, 2=CSR/debug). Grants are combinational
//   valid/ready, the winning write is registered one stage ahead of the
//   register file, and a 32-entry scoreboard tracks outstanding writes for
//   RAW stall detection in the issue stage.
//
//   Ports
//     clock   in  rising-edge clock
//     reset   in  asynchronous, active-high
//     bus     regfile_wb_arbiter_if.slave (request bus, rf write port,
//             scoreboard set/busy)
//
//   Configuration macro
//     REGFILE_ARB_FIXED_PRIO_EN : fixed priority, lowest index wins, no
//                                 round-robin pointer. Undefined (default):
//                                 round-robin starting at requester 0.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clock,
    input  logic               reset,
    regfile_wb_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Unpacked views of the flattened request slices.
    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
            assign data_arr[gi] = bus.req_data[gi*DW +: DW];
        end
    endgenerate

    logic          grant_vld;   // a transfer happens this cycle
    logic [PW-1:0] grant_idx;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is the last write.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(i);
            end
        end
        if (bus.hold) begin
            grant_vld = 1'b0;
        end
    end
`else
    logic [PW-1:0] rr_q;
    logic [PW-1:0] rr_d;

    // Search rr_q+1 .. rr_q+NREQ; walking the offsets downward lets the
    // nearest valid requester overwrite any farther one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(rr_q) + k) % NREQ]) begin
                grant_vld = 1'b1;
                grant_idx = PW'((int'(rr_q) + k) % NREQ);
            end
        end
        if (bus.hold) begin
            grant_vld = 1'b0;
        end
    end

    // The pointer only moves on an actual transfer, so hold freezes it.
    assign rr_d = grant_vld ? grant_idx : rr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= PW'(NREQ - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Grant does not look at ready, so it is one-hot or zero by construction.
    always_comb begin
        bus.req_ready = '0;
        if (grant_vld) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          rf_we_d;

    assign win_addr = addr_arr[grant_idx];
    assign win_data = data_arr[grant_idx];
    // Writes to x0 are accepted but never reach the register file.
    assign rf_we_d  = grant_vld && (win_addr != '0);

    logic          rf_we_q;
    logic [AW-1:0] rf_a3_q;
    logic [DW-1:0] rf_wd3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            if (grant_vld) begin
                rf_a3_q  <= win_addr;
                rf_wd3_q <= win_data;
            end
        end
    end

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_wd3 = rf_wd3_q;

    // Scoreboard: the edge that registers rf_we=1 for xr clears busy[r];
    // a same-edge allocation of xr belongs to a newer producer and wins.
    logic [31:0] sb_busy_q;
    logic [31:0] sb_busy_d;

    assign sb_busy_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_sb
            logic set_hit;
            logic clr_hit;
            assign set_hit = bus.sb_set && (32'(bus.sb_addr) == gi);
            assign clr_hit = rf_we_d && (32'(win_addr) == gi);
            assign sb_busy_d[gi] = set_hit | (sb_busy_q[gi] & ~clr_hit);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_busy_q <= '0;
        end else begin
            sb_busy_q <= sb_busy_d;
        end
    end

    assign bus.sb_busy = sb_busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed table of per-cycle stimulus with expected grant (before the
//   edge) and expected registered outputs/scoreboard (after the edge), plus
//   hand-written sequences for hold completion and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock;
    logic reset;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        set;
        logic [4:0]  saddr;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        logic [31:0] e_busy;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic hold, input logic [2:0] valid,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic set, input logic [4:0] saddr);
        bus.hold      = hold;
        bus.req_valid = valid;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {d2, d1, d0};
        bus.sb_set    = set;
        bus.sb_addr   = saddr;
    endtask

    function automatic vec_t mk(logic hold, logic [2:0] valid,
                                logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic set, logic [4:0] saddr,
                                logic [2:0] e_ready, logic e_we, logic [4:0] e_a3,
                                logic [31:0] e_wd3, logic [31:0] e_busy);
        vec_t v;
        v.hold = hold; v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.set = set; v.saddr = saddr;
        v.e_ready = e_ready; v.e_we = e_we; v.e_a3 = e_a3; v.e_wd3 = e_wd3;
        v.e_busy = e_busy;
        return v;
    endfunction

    localparam logic [31:0] B4  = 32'h0000_0010;
    localparam logic [31:0] B7  = 32'h0000_0080;
    localparam logic [31:0] B9  = 32'h0000_0200;
    localparam logic [31:0] B12 = 32'h0000_1000;

    vec_t tbl [18];

    initial begin
        // Rows 0-3: all requesters valid, addrs 1/2/3 held.
        tbl[0]  = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     3'b001, 1, 1, 32'h11, 0);
        tbl[1]  = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     FIXED ? 3'b001 : 3'b010, 1, FIXED ? 5'd1 : 5'd2,
                     FIXED ? 32'h11 : 32'h22, 0);
        tbl[2]  = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     FIXED ? 3'b001 : 3'b100, 1, FIXED ? 5'd1 : 5'd3,
                     FIXED ? 32'h11 : 32'h33, 0);
        tbl[3]  = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     3'b001, 1, 1, 32'h11, 0);
        // Single LSU write to x5, then idle: rf_we drops, a3/wd3 retained.
        tbl[4]  = mk(0, 3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0,
                     3'b010, 1, 5, 32'hDEADBEEF, 0);
        tbl[5]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0,
                     3'b000, 0, 5, 32'hDEADBEEF, 0);
        // Allocate x7, LSU writes x7 -> busy cleared on that edge.
        tbl[6]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7,
                     3'b000, 0, 5, 32'hDEADBEEF, B7);
        tbl[7]  = mk(0, 3'b010, 0, 7, 0, 0, 32'h77, 0, 0, 0,
                     3'b010, 1, 7, 32'h77, 0);
        // Allocate x4, then ALU writes x0: accepted, no rf_we, busy unchanged.
        tbl[8]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4,
                     3'b000, 0, 7, 32'h77, B4);
        tbl[9]  = mk(0, 3'b001, 0, 0, 0, 32'h1234, 0, 0, 0, 0,
                     3'b001, 0, 0, 32'h1234, B4);
        // Allocate x9, CSR writes x9 -> cleared; then set+write same edge -> set wins.
        tbl[10] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9,
                     3'b000, 0, 0, 32'h1234, B4 | B9);
        tbl[11] = mk(0, 3'b100, 0, 0, 9, 0, 0, 32'h99, 0, 0,
                     3'b100, 1, 9, 32'h99, B4);
        tbl[12] = mk(0, 3'b100, 0, 0, 9, 0, 0, 32'h999, 1, 9,
                     3'b100, 1, 9, 32'h999, B4 | B9);
        // hold with all valid: no grants, no write.
        tbl[13] = mk(1, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     3'b000, 0, 9, 32'h999, B4 | B9);
        // x1 write (not busy: clear has no effect), hold, x0 allocate ignored.
        tbl[14] = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     3'b001, 1, 1, 32'h11, B4 | B9);
        tbl[15] = mk(1, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     3'b000, 0, 1, 32'h11, B4 | B9);
        tbl[16] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0,
                     3'b000, 0, 1, 32'h11, B4 | B9);
        // Pointer stayed frozen through the hold: next winner follows requester 0.
        tbl[17] = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0,
                     FIXED ? 3'b001 : 3'b010, 1, FIXED ? 5'd1 : 5'd2,
                     FIXED ? 32'h11 : 32'h22, B4 | B9);

        // Reset state
        reset = 1'b1;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        chk("reset_we",   32'(bus.rf_we), 0);
        chk("reset_a3",   32'(bus.rf_a3), 0);
        chk("reset_wd3",  bus.rf_wd3, 0);
        chk("reset_busy", bus.sb_busy, 0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].hold, tbl[i].valid, tbl[i].a0, tbl[i].a1, tbl[i].a2,
                  tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].set, tbl[i].saddr);
            #1;
            chk($sformatf("row%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
            @(posedge clock); #1;
            chk($sformatf("row%0d_we", i),   32'(bus.rf_we),  32'(tbl[i].e_we));
            chk($sformatf("row%0d_a3", i),   32'(bus.rf_a3),  32'(tbl[i].e_a3));
            chk($sformatf("row%0d_wd3", i),  bus.rf_wd3,      tbl[i].e_wd3);
            chk($sformatf("row%0d_busy", i), bus.sb_busy,     tbl[i].e_busy);
            $display("row %0d: ready=%b we=%b a3=%0d wd3=%h busy=%h",
                     i, tbl[i].e_ready, bus.rf_we, bus.rf_a3, bus.rf_wd3, bus.sb_busy);
        end

        // Hold right after an accepted write: the write still completes.
        drive(0, 3'b001, 3, 0, 0, 32'h333, 0, 0, 0, 0);
        #1;
        chk("holdseq_ready0", 32'(bus.req_ready), 32'b001);
        @(posedge clock); #1;
        drive(1, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0);
        #1;
        chk("holdseq_ready1", 32'(bus.req_ready), 0);
        chk("holdseq_we1",    32'(bus.rf_we), 1);
        chk("holdseq_a3",     32'(bus.rf_a3), 3);
        chk("holdseq_wd3",    bus.rf_wd3, 32'h333);
        @(posedge clock); #1;
        chk("holdseq_we2",    32'(bus.rf_we), 0);
        $display("holdseq: write x3 completed during hold");

        // Reset asserted mid-cycle while rf_we=1 and the scoreboard is populated.
        drive(0, 3'b010, 0, 5, 0, 0, 32'h55, 0, 1, 12);
        @(posedge clock); #1;
        chk("rstseq_we_pre",   32'(bus.rf_we), 1);
        chk("rstseq_busy_pre", bus.sb_busy, B4 | B9 | B12);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rstseq_we",   32'(bus.rf_we), 0);
        chk("rstseq_busy", bus.sb_busy, 0);
        chk("rstseq_a3",   32'(bus.rf_a3), 0);
        chk("rstseq_wd3",  bus.rf_wd3, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        $display("rstseq: async reset cleared write stage and scoreboard");

        // After reset the pointer restarts: requester 0 first, then 1.
        drive(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0);
        #1;
        chk("postrst_ready0", 32'(bus.req_ready), 32'b001);
        @(posedge clock); #1;
        chk("postrst_a3_0", 32'(bus.rf_a3), 1);
        chk("postrst_ready1", 32'(bus.req_ready), FIXED ? 32'b001 : 32'b010);
        @(posedge clock); #1;
        chk("postrst_a3_1", 32'(bus.rf_a3), FIXED ? 32'd1 : 32'd2);
        $display("postrst: a3=%0d", bus.rf_a3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
